elastic_unshift: RTL



---
 rtl/elastic_unshift.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/elastic_unshift.sv
// Receive-side unscaler: 2-entry skid buffer that right-shifts accepted words by SHIFT,
// flags words with non-zero low bits and counts delivered beats.
// Optional build macro ELASTIC_UNSHIFT_DROP_EN drops flagged words and adds drop_cnt.
module elastic_unshift #(
    parameter int unsigned DW    = 32,
    parameter int unsigned SHIFT = 2,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DW-1:0]    t0_data,
    input  logic             t0_valid,
    output logic             t0_ready,
    output logic [DW-1:0]    i0_data,
    output logic             i0_valid,
    input  logic             i0_ready,
    input  logic             err_clr,
    output logic             err_low_bits,
    output logic [CNT_W-1:0] beat_cnt
`ifdef ELASTIC_UNSHIFT_DROP_EN
    ,
    output logic [CNT_W-1:0] drop_cnt
`endif
);

    typedef enum logic [1:0] {
        StEmpty,
        StBusy,
        StFull
    } state_e;

    state_e           state_q, state_d;
    logic [DW-1:0]    out_q, out_d;
    logic [DW-1:0]    skid_q, skid_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] beat_q, beat_d;

    logic             accept;
    logic             deliver;
    logic             low_bits_set;
    logic             enq;
    logic [DW-1:0]    shifted;

    // Ready depends only on registered state and rst, never on i0_ready.
    assign t0_ready     = (state_q != StFull) && !rst;
    assign i0_valid     = (state_q != StEmpty);
    assign i0_data      = out_q;
    assign err_low_bits = err_q;
    assign beat_cnt     = beat_q;

    assign accept       = t0_valid && t0_ready;
    assign deliver      = i0_valid && i0_ready;
    assign low_bits_set = |t0_data[SHIFT-1:0];
    assign shifted      = t0_data >> SHIFT;

`ifdef ELASTIC_UNSHIFT_DROP_EN
    // Flagged words complete the handshake but never enter the buffer.
    assign enq = accept && !low_bits_set;
`else
    assign enq = accept;
`endif

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        unique case (state_q)
            StEmpty: begin
                if (enq) begin
                    state_d = StBusy;
                    out_d   = shifted;
                end
            end
            StBusy: begin
                if (enq && deliver) begin
                    out_d = shifted;
                end else if (enq) begin
                    state_d = StFull;
                    skid_d  = shifted;
                end else if (deliver) begin
                    state_d = StEmpty;
                end
            end
            StFull: begin
                if (deliver) begin
                    state_d = StBusy;
                    out_d   = skid_q;
                end
            end
            default: begin
                state_d = StEmpty;
            end
        endcase
    end

    always_comb begin
        err_d = err_q;
        if (err_clr) begin
            err_d = 1'b0;
        end
        // A new error in the clearing cycle wins.
        if (accept && low_bits_set) begin
            err_d = 1'b1;
        end
    end

    always_comb begin
        beat_d = beat_q;
        if (deliver) begin
            beat_d = beat_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StEmpty;
            out_q   <= '0;
            skid_q  <= '0;
            err_q   <= 1'b0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            skid_q  <= skid_d;
            err_q   <= err_d;
            beat_q  <= beat_d;
        end
    end

`ifdef ELASTIC_UNSHIFT_DROP_EN
    logic [CNT_W-1:0] drop_q, drop_d;

    assign drop_cnt = drop_q;

    always_comb begin
        drop_d = drop_q;
        if (accept && low_bits_set) begin
            drop_d = drop_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_q <= '0;
        end else begin
            drop_q <= drop_d;
        end
    end
`endif

endmodule
